recon_hdr_tx: RTL
=================

Name:
recon_hdr_tx

Overview:
- Transmit-side counterpart of the recon header parser. Takes one command (func_type, bitstream addr/id/size) plus an optional payload stream, e.g. DMA read data or a bitstream segment.
- Emits one AXI-Stream frame per command: 46-byte Eth/IP/RMT prefix, then a 10-byte recon header at bytes 46..55, then the byte-packed payload.
- Sits between the DMA read engine / app logic and the Ethernet TX path of the app block.

Parameters:
- DATA_WIDTH, 512, stream width in bits. Only 512 is supported; elaboration error otherwise.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ADDR_WIDTH, 34, bitstream address width.
- PREFIX_BYTES, 46, Eth/IP/RMT prefix length in bytes.
- RECON_HDR_BYTES, 10, recon header length in bytes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command ready.
- s_cmd_prefix  in  368  prefix bytes; byte 0 = bits [7:0].
- s_cmd_func_type  in  2  00 = write, 01 = read.
- s_cmd_size_valid  in  1  1 = descriptor-only frame, no payload.
- s_cmd_addr  in  ADDR_WIDTH  bitstream address.
- s_cmd_id  in  8  bitstream id.
- s_cmd_size  in  32  bitstream size in bytes.
- s_payload_tdata  in  DATA_WIDTH  payload data.
- s_payload_tkeep  in  KEEP_WIDTH  payload keep; contiguous from bit 0; all-ones except on the last beat.
- s_payload_tvalid  in  1  payload valid.
- s_payload_tlast  in  1  payload last.
- s_payload_tready  out  1  payload ready.
- m_axis_tdata  out  DATA_WIDTH  frame data.
- m_axis_tkeep  out  KEEP_WIDTH  frame keep.
- m_axis_tvalid  out  1  frame valid.
- m_axis_tlast  out  1  frame last.
- m_axis_tready  in  1  frame ready.
- busy  out  1  high from command accept until the last beat handshakes.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, except s_cmd_ready = 1 once in IDLE.
- Recon header bit layout (header bit 0 = byte 46 bit 0), remaining bits zero:
  - [1:0] func_type
  - [2] size_valid
  - [36:3] addr
  - [44:37] id
  - [76:45] size
- Output register: a single register drives m_axis_*. It loads only when empty or when m_axis_tvalid && m_axis_tready. m_axis_* stay stable while tvalid && !tready.
- s_payload_tready = in PAYLOAD state && output register loadable. There is no combinational path from s_payload_tvalid to s_payload_tready.
- IDLE:
  - s_cmd_ready = 1.
  - On cmd handshake: latch all command fields, go to HDR.
- HDR:
  - Build beat 0: bytes 0..45 = prefix, bytes 46..55 = recon header.
  - If size_valid = 1: load beat with tkeep = 0x00FF_FFFF_FFFF_FFFF (56 bytes) and tlast = 1, go to DRAIN.
  - Else wait for a payload beat P0. Bytes 56..63 of beat 0 = P0 bytes 0..7. Hold P0 bytes 8..63 in a residue register, go to PAYLOAD.
  - The first output beat is valid 1 cycle after the cmd handshake (descriptor-only case), or 1 cycle after the P0 handshake.
- PAYLOAD:
  - For each payload beat Pn: output = residue (bytes 0..55) | Pn bytes 0..7 (bytes 56..63). Residue <= Pn bytes 8..63.
- Tail handling, with k = popcount(last beat tkeep):
  - k <= 8: that output beat is final. tkeep = 56 + k bytes, tlast = 1, go to DRAIN.
  - k > 8: that beat has full keep and tlast = 0. Go to TAIL, which emits the residue with tkeep = k-8 bytes and tlast = 1 without consuming input, then go to DRAIN.
  - If the payload is a single beat (P0 carries tlast): apply the same k rule to beat 0.
- DRAIN: wait for the last beat handshake, then go to IDLE. s_cmd_ready rises the following cycle. Commands are not pipelined: max 1 frame in flight.
- s_payload beats are never consumed while in IDLE, HDR-with-size_valid, TAIL or DRAIN.
- rst_n asserted mid-frame: frame aborted immediately, m_axis_tvalid = 0, no tlast emitted. Partially received payload is discarded by upstream.
- The size field is transmitted verbatim; it is not checked against the payload unless the optional feature is enabled.

Optional Feature:
- Macro: RECON_TX_LEN_CHECK_EN.
- Defined:
  - A 32-bit counter sums popcount(tkeep) of accepted payload beats.
  - At payload tlast, if the count differs from latched size (and size_valid = 0): one-cycle pulse on extra output len_err, and the counter clears.
  - The frame is still emitted unchanged.
- Undefined: len_err port absent, no counter.

Test Plan:
- Descriptor-only: size_valid = 1, func 01, addr 0x3_0000_1000, id 0x5A, size 0x4000 -> one beat, tkeep = 0x00FF_FFFF_FFFF_FFFF, tlast = 1. Bytes 46..55 decode to the same fields. No payload beat consumed.
- Single payload beat with k = 8 (bytes 0x00..0x07) -> one beat, tkeep all ones, bytes 56..63 = 0x00..0x07, tlast = 1.
- Three payload beats, the last with k = 20 (148 bytes total) -> 4 output beats; last beat tkeep = 0xFFF, tlast = 1. Byte stream after offset 56 equals the input byte stream.
- Backpressure: m_axis_tready toggled 1-0-0-1 per cycle during the 3-beat case -> data/keep stable during stalls, no beats lost or duplicated, s_payload_tready low while stalled.
- Reset: rst_n pulled low during PAYLOAD -> m_axis_tvalid = 0 asynchronously; after release, s_cmd_ready = 1 and the next command produces a correct frame.
- With RECON_TX_LEN_CHECK_EN: size = 100, payload 148 bytes -> one-cycle len_err pulse at the tlast beat. With size = 148 -> no pulse.

Source files
------------

// File: rtl/recon_hdr_tx_if.sv
// rtl/recon_hdr_tx_if.sv - command, payload stream and frame stream bundle for recon_hdr_tx
interface recon_hdr_tx_if #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH   = 34,
  parameter int PREFIX_BYTES = 46
);
  // command
  logic                      s_cmd_valid;
  logic                      s_cmd_ready;
  logic [PREFIX_BYTES*8-1:0] s_cmd_prefix;
  logic [1:0]                s_cmd_func_type;
  logic                      s_cmd_size_valid;
  logic [ADDR_WIDTH-1:0]     s_cmd_addr;
  logic [7:0]                s_cmd_id;
  logic [31:0]               s_cmd_size;

  // payload stream
  logic [DATA_WIDTH-1:0]     s_payload_tdata;
  logic [KEEP_WIDTH-1:0]     s_payload_tkeep;
  logic                      s_payload_tvalid;
  logic                      s_payload_tlast;
  logic                      s_payload_tready;

  // frame stream
  logic [DATA_WIDTH-1:0]     m_axis_tdata;
  logic [KEEP_WIDTH-1:0]     m_axis_tkeep;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic                      m_axis_tready;

  modport slave (
    input  s_cmd_valid, s_cmd_prefix, s_cmd_func_type, s_cmd_size_valid,
           s_cmd_addr, s_cmd_id, s_cmd_size,
    output s_cmd_ready,
    input  s_payload_tdata, s_payload_tkeep, s_payload_tvalid, s_payload_tlast,
    output s_payload_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_cmd_valid, s_cmd_prefix, s_cmd_func_type, s_cmd_size_valid,
           s_cmd_addr, s_cmd_id, s_cmd_size,
    input  s_cmd_ready,
    output s_payload_tdata, s_payload_tkeep, s_payload_tvalid, s_payload_tlast,
    input  s_payload_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/recon_hdr_tx.sv
// rtl/recon_hdr_tx.sv - recon header frame builder; optional payload length check under RECON_TX_LEN_CHECK_EN
module recon_hdr_tx #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 34,
  parameter int PREFIX_BYTES    = 46,
  parameter int RECON_HDR_BYTES = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  recon_hdr_tx_if.slave bus,
  output logic         busy
`ifdef RECON_TX_LEN_CHECK_EN
  ,
  output logic         len_err
`endif
);

  localparam int HEAD_BYTES  = PREFIX_BYTES + RECON_HDR_BYTES;  // bytes 0..55 of beat 0
  localparam int HEAD_BITS   = HEAD_BYTES * 8;
  localparam int HDR_BITS    = RECON_HDR_BYTES * 8;
  localparam int SPILL_BYTES = KEEP_WIDTH - HEAD_BYTES;         // payload bytes fitting after the head
  localparam int SPILL_BITS  = SPILL_BYTES * 8;
  localparam int CW          = $clog2(KEEP_WIDTH + 1);
  localparam int ID_LSB      = 3 + ADDR_WIDTH;
  localparam int SIZE_LSB    = ID_LSB + 8;

  generate
    if (DATA_WIDTH != 512) begin : g_bad_width
      $error("recon_hdr_tx: only DATA_WIDTH = 512 is supported");
    end
    if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep
      $error("recon_hdr_tx: KEEP_WIDTH must equal DATA_WIDTH/8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_TAIL,
    S_DRAIN
  } state_t;

  function automatic logic [CW-1:0] keep_count(input logic [KEEP_WIDTH-1:0] keep);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + CW'(keep[i]);
    return c;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [CW-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  // Prefix followed by the recon header, i.e. bytes 0..55 of the first beat.
  function automatic logic [HEAD_BITS-1:0] build_head(
    input logic [PREFIX_BYTES*8-1:0] prefix,
    input logic [1:0]                func,
    input logic                      size_valid,
    input logic [ADDR_WIDTH-1:0]     addr,
    input logic [7:0]                id,
    input logic [31:0]               size
  );
    logic [HDR_BITS-1:0] h;
    h                   = '0;
    h[1:0]              = func;
    h[2]                = size_valid;
    h[3 +: ADDR_WIDTH]  = addr;
    h[ID_LSB +: 8]      = id;
    h[SIZE_LSB +: 32]   = size;
    return {h, prefix};
  endfunction

  state_t                 state_q, state_d;
  logic [HEAD_BITS-1:0]   residue_q;     // bytes waiting for the next output beat
  logic [CW-1:0]          tail_cnt_q;    // valid residue bytes for the TAIL beat
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [KEEP_WIDTH-1:0]  out_keep_q;
  logic                   out_last_q;

  logic                   load_ok;
  logic                   cmd_fire;
  logic                   pay_fire;
  logic                   last_fire;
  logic [CW-1:0]          pay_cnt;
  logic [HEAD_BITS-1:0]   head_in;

  logic                   cmd_ready;
  logic                   pay_ready;
  logic                   load_en;
  logic [DATA_WIDTH-1:0]  beat_data;
  logic [KEEP_WIDTH-1:0]  beat_keep;
  logic                   beat_last;

  assign load_ok   = !out_valid_q || bus.m_axis_tready;
  assign cmd_fire  = (state_q == S_IDLE) && bus.s_cmd_valid;
  assign pay_fire  = pay_ready && bus.s_payload_tvalid;
  assign last_fire = out_valid_q && out_last_q && bus.m_axis_tready;
  assign pay_cnt   = keep_count(bus.s_payload_tkeep);
  assign head_in   = build_head(bus.s_cmd_prefix, bus.s_cmd_func_type, bus.s_cmd_size_valid,
                                bus.s_cmd_addr, bus.s_cmd_id, bus.s_cmd_size);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: descriptor-only commands skip straight to DRAIN since beat 0 loads at accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) state_d = bus.s_cmd_size_valid ? S_DRAIN : S_HDR;
      end
      S_HDR, S_PAYLOAD: begin
        if (pay_fire) begin
          if (!bus.s_payload_tlast)                state_d = S_PAYLOAD;
          else if (pay_cnt <= CW'(SPILL_BYTES))    state_d = S_DRAIN;
          else                                     state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (load_ok) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: handshake readies and the beat offered to the output register.
  always_comb begin
    cmd_ready = 1'b0;
    pay_ready = 1'b0;
    load_en   = 1'b0;
    beat_data = '0;
    beat_keep = '0;
    beat_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.s_cmd_valid && bus.s_cmd_size_valid) begin
          load_en   = 1'b1;
          beat_data = {{SPILL_BITS{1'b0}}, head_in};
          beat_keep = keep_mask(CW'(HEAD_BYTES));
          beat_last = 1'b1;
        end
      end
      S_HDR, S_PAYLOAD: begin
        // HDR and PAYLOAD differ only in what residue_q holds (head vs previous beat's upper bytes).
        pay_ready = load_ok;
        if (load_ok && bus.s_payload_tvalid) begin
          load_en   = 1'b1;
          beat_data = {bus.s_payload_tdata[SPILL_BITS-1:0], residue_q};
          if (bus.s_payload_tlast && (pay_cnt <= CW'(SPILL_BYTES))) begin
            beat_keep = keep_mask(CW'(HEAD_BYTES) + pay_cnt);
            beat_last = 1'b1;
          end else begin
            beat_keep = '1;
          end
        end
      end
      S_TAIL: begin
        if (load_ok) begin
          load_en   = 1'b1;
          beat_data = {{SPILL_BITS{1'b0}}, residue_q};
          beat_keep = keep_mask(tail_cnt_q);
          beat_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Residue: head bytes at command accept, then the upper 56 bytes of each payload beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue_q  <= '0;
      tail_cnt_q <= '0;
    end else if (cmd_fire) begin
      residue_q  <= head_in;
    end else if (pay_fire) begin
      residue_q  <= bus.s_payload_tdata[DATA_WIDTH-1:SPILL_BITS];
      tail_cnt_q <= pay_cnt - CW'(SPILL_BYTES);
    end
  end

  // Output register: loads when empty or draining, holds steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= 1'b1;
      out_data_q  <= beat_data;
      out_keep_q  <= beat_keep;
      out_last_q  <= beat_last;
    end else if (bus.m_axis_tready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef RECON_TX_LEN_CHECK_EN
  logic [31:0] len_cnt_q;
  logic [31:0] len_size_q;
  logic        len_sv_q;
  logic        len_err_q;
  logic [31:0] len_total;

  assign len_total = len_cnt_q + 32'(pay_cnt);

  // Payload byte count compared with the declared size at the payload tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt_q  <= '0;
      len_size_q <= '0;
      len_sv_q   <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (cmd_fire) begin
        len_cnt_q  <= '0;
        len_size_q <= bus.s_cmd_size;
        len_sv_q   <= bus.s_cmd_size_valid;
      end else if (pay_fire) begin
        if (bus.s_payload_tlast) begin
          len_cnt_q <= '0;
          len_err_q <= (len_total != len_size_q) && !len_sv_q;
        end else begin
          len_cnt_q <= len_total;
        end
      end
    end
  end

  assign len_err = len_err_q;
`endif

  assign bus.s_cmd_ready      = cmd_ready;
  assign bus.s_payload_tready = pay_ready;
  assign bus.m_axis_tdata     = out_data_q;
  assign bus.m_axis_tkeep     = out_keep_q;
  assign bus.m_axis_tvalid    = out_valid_q;
  assign bus.m_axis_tlast     = out_last_q;
  assign busy                 = (state_q != S_IDLE);

endmodule
